// File: rtl/dcsk_demodulator.sv
// rtl/dcsk_demodulator.sv - DCSK receiver: correlates info chips against stored reference chips per frame
package spreading_factors_pkg;
  typedef enum logic [1:0] {SF2 = 2'd0, SF4 = 2'd1, SF8 = 2'd2, SF16 = 2'd3} sf_t;
endpackage

module dcsk_demodulator
  import spreading_factors_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 2*DATA_W+4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  sf_t                      sf_i,
  input  logic                     sync_i,
  input  logic                     in_valid_i,
  input  logic signed [DATA_W-1:0] in_sample_i,
  output logic                     out_valid_o,
  output logic                     out_bit_o,
  output logic signed [ACC_W-1:0]  out_corr_o,
  output logic                     busy_o
);

  typedef enum logic {ST_REF = 1'b0, ST_INFO = 1'b1} state_t;

  state_t                    state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  sf_t                       sf_q, sf_d;
  sf_t                       sf_cur;
  logic [3:0]                last_idx;
  logic signed [DATA_W-1:0]  ref_buf [16];
  logic signed [2*DATA_W-1:0] product;
  logic signed [ACC_W-1:0]   product_ext;
  logic signed [ACC_W-1:0]   acc_sum;
  logic                      ref_we;
  logic                      frame_done;

  // At reference chip 0 the frame length comes straight from sf_i, since sf_q is only being latched now.
  always_comb begin
    sf_cur = (state_q == ST_REF && cnt_q == 4'd0) ? sf_i : sf_q;
    case (sf_cur)
      SF2:     last_idx = 4'd1;
      SF4:     last_idx = 4'd3;
      SF8:     last_idx = 4'd7;
      default: last_idx = 4'd15;
    endcase
  end

  always_comb begin
    product     = ref_buf[cnt_q] * in_sample_i;
    product_ext = ACC_W'(product);
    acc_sum     = acc_q + product_ext;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    sf_d       = sf_q;
    ref_we     = 1'b0;
    frame_done = 1'b0;
    if (sync_i) begin
      state_d = ST_REF;
      cnt_d   = 4'd0;
      acc_d   = '0;
    end else if (in_valid_i) begin
      case (state_q)
        ST_REF: begin
          ref_we = 1'b1;
          if (cnt_q == 4'd0) sf_d = sf_i;
          if (cnt_q == last_idx) begin
            state_d = ST_INFO;
            cnt_d   = 4'd0;
            acc_d   = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: begin
          acc_d = acc_sum;
          if (cnt_q == last_idx) begin
            state_d    = ST_REF;
            cnt_d      = 4'd0;
            acc_d      = '0;
            frame_done = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_REF;
      cnt_q       <= 4'd0;
      acc_q       <= '0;
      sf_q        <= SF2;
      out_valid_o <= 1'b0;
      out_bit_o   <= 1'b0;
      out_corr_o  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      sf_q        <= sf_d;
      out_valid_o <= frame_done;
      if (frame_done) begin
        out_corr_o <= acc_sum;
        out_bit_o  <= ~acc_sum[ACC_W-1];
      end
    end
  end

  // Buffer contents are meaningless outside a frame, so they carry no reset.
  always_ff @(posedge clk) begin
    if (ref_we) ref_buf[cnt_q] <= in_sample_i;
  end

  assign busy_o = (state_q != ST_REF) || (cnt_q != 4'd0);

endmodule

// File: tb/tb_dcsk_demodulator.sv
// tb/tb_dcsk_demodulator.sv - directed vector bench for dcsk_demodulator
module tb_dcsk_demodulator;
  import spreading_factors_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  sf_t                sf;
  logic               sync;
  logic               in_valid;
  logic signed [7:0]  in_sample;
  logic               out_valid;
  logic               out_bit;
  logic signed [19:0] out_corr;
  logic               busy;

  dcsk_demodulator dut (
    .clk(clk), .rst_n(rst_n), .sf_i(sf), .sync_i(sync), .in_valid_i(in_valid),
    .in_sample_i(in_sample), .out_valid_o(out_valid), .out_bit_o(out_bit),
    .out_corr_o(out_corr), .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    sf_t              sf;
    int               n;
    int               gap;
    int               corr;
    logic             b;
    logic signed [7:0] ch [32];
  } vec_t;

  vec_t vecs [5];
  logic signed [7:0] fr [32];
  int n_cmp = 0;
  int n_fail = 0;
  int pulses = 0;

  always @(negedge clk) if (out_valid) pulses++;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic signed [7:0] s);
    in_valid  = 1'b1;
    in_sample = s;
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  task automatic idle(input int c);
    repeat (c) begin @(posedge clk); @(negedge clk); end
  endtask

  task automatic play_frame(input string name, input sf_t s, input int n, input int gap,
                            input int corr, input logic b);
    int p0;
    p0 = pulses;
    sf = s;
    for (int i = 0; i < 2*n; i++) begin
      if (i > 0 && gap > 0) idle($urandom_range(0, gap));
      send(fr[i]);
      if (i == 0) check({name, " busy after chip0"}, busy, 1);
    end
    check({name, " out_valid"}, out_valid, 1);
    check({name, " corr"}, out_corr, corr);
    check({name, " bit"}, out_bit, b);
    idle(2);
    check({name, " out_valid low"}, out_valid, 0);
    check({name, " one pulse"}, pulses - p0, 1);
    check({name, " busy idle"}, busy, 0);
  endtask

  initial begin
    int p0;
    // SF2 matched
    vecs[0].sf = SF2;  vecs[0].n = 2;  vecs[0].gap = 0; vecs[0].corr = 13; vecs[0].b = 1'b1;
    vecs[0].ch[0] = 3; vecs[0].ch[1] = -2; vecs[0].ch[2] = 3; vecs[0].ch[3] = -2;
    // SF4 inverted, gappy valid
    vecs[1].sf = SF4;  vecs[1].n = 4;  vecs[1].gap = 3; vecs[1].corr = -30; vecs[1].b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vecs[1].ch[i] = 8'(i + 1);
      vecs[1].ch[i+4] = 8'(-(i + 1));
    end
    // SF16 extreme magnitude
    vecs[2].sf = SF16; vecs[2].n = 16; vecs[2].gap = 0; vecs[2].corr = 262144; vecs[2].b = 1'b1;
    for (int i = 0; i < 32; i++) vecs[2].ch[i] = -8'sd128;
    // SF2 zero correlation decides 1
    vecs[3].sf = SF2;  vecs[3].n = 2;  vecs[3].gap = 1; vecs[3].corr = 0; vecs[3].b = 1'b1;
    vecs[3].ch[0] = 1; vecs[3].ch[1] = 1; vecs[3].ch[2] = 1; vecs[3].ch[3] = -1;
    // SF8 alternating info: 1-2+3-4+5-6+7-8
    vecs[4].sf = SF8;  vecs[4].n = 8;  vecs[4].gap = 2; vecs[4].corr = -4; vecs[4].b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vecs[4].ch[i] = 8'(i + 1);
      vecs[4].ch[i+8] = (i % 2 == 0) ? 8'sd1 : -8'sd1;
    end

    rst_n = 1'b0; sf = SF2; sync = 1'b0; in_valid = 1'b0; in_sample = '0;
    idle(3);
    rst_n = 1'b1;
    check("reset out_valid", out_valid, 0);
    check("reset out_bit", out_bit, 0);
    check("reset out_corr", out_corr, 0);
    check("reset busy", busy, 0);

    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 32; i++) fr[i] = vecs[v].ch[i];
      play_frame($sformatf("vec%0d", v), vecs[v].sf, vecs[v].n, vecs[v].gap,
                 vecs[v].corr, vecs[v].b);
    end

    // sf_i changes mid-frame: SF4 frame still ends after 8 chips
    p0 = pulses;
    sf = SF4;
    send(1); send(1);
    sf = SF16;
    for (int i = 0; i < 6; i++) send(1);
    check("sfswitch out_valid", out_valid, 1);
    check("sfswitch corr", out_corr, 4);
    for (int i = 0; i < 31; i++) send(2);
    check("sf16 no early pulse", pulses - p0, 1);
    send(2);
    check("sf16 out_valid", out_valid, 1);
    check("sf16 corr", out_corr, 64);

    // sync at chip 5 of SF8 frame
    sf = SF8;
    for (int i = 0; i < 5; i++) send(3);
    sync = 1'b1;
    send(7);
    sync = 1'b0;
    check("sync busy", busy, 0);
    check("sync out_valid", out_valid, 0);
    check("sync corr kept", out_corr, 64);
    fr[0] = 2; fr[1] = 2; fr[2] = -1; fr[3] = -1;
    play_frame("postsync", SF2, 2, 0, -4, 1'b0);

    // reset mid SF4 frame
    sf = SF4;
    send(5); send(5); send(5);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    check("midrst out_corr", out_corr, 0);
    check("midrst out_bit", out_bit, 0);
    check("midrst busy", busy, 0);
    fr[0] = 3; fr[1] = -2; fr[2] = 3; fr[3] = -2;
    play_frame("postrst", SF2, 2, 0, 13, 1'b1);

    // three back-to-back SF2 frames: corr 2, -2, 5
    begin
      logic signed [7:0] bb [12];
      int exp_corr [3];
      bb = '{1, 1, 1, 1,  1, 1, -1, -1,  2, 3, 1, 1};
      exp_corr = '{2, -2, 5};
      sf = SF2;
      for (int k = 1; k <= 12; k++) begin
        send(bb[k-1]);
        check($sformatf("b2b cycle%0d out_valid", k + 1), out_valid, (k % 4 == 0));
        if (k % 4 == 0) begin
          check($sformatf("b2b frame%0d corr", k / 4), out_corr, exp_corr[k/4-1]);
          check($sformatf("b2b frame%0d bit", k / 4), out_bit, exp_corr[k/4-1] >= 0);
        end
      end
      idle(1);
      check("b2b busy end", busy, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
